pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter PAYLOAD_W, default 74, meaning the width of the opaque stage payload (e.g. w_addr + w_data + mem_addr + aluop).
REQ-002 SHALL provide parameter STALL_W, default 6, meaning the width of the pipeline stall vector.
REQ-003 SHALL provide parameter STAGE, default 3, meaning the stall-vector index of the upstream stage; legal range 0..STALL_W-2.
REQ-004 SHALL provide parameter CNT_W, default 16, meaning the width of each performance counter.
REQ-005 SHALL provide parameter NOP_PAYLOAD, default all-zero of PAYLOAD_W, meaning the payload loaded on reset, bubble or flush.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 stall  input  STALL_W  pipeline stall vector; bit STAGE is upstream stall, bit STAGE+1 is downstream stall.
REQ-009 flush  input  1  kill the stage contents (branch or exception redirect).
REQ-010 in_valid  input  1  upstream stage holds a real instruction.
REQ-011 in_w_enable  input  1  upstream register-write enable.
REQ-012 in_payload  input  PAYLOAD_W  upstream payload.
REQ-013 out_valid  output  1  registered valid.
REQ-014 out_w_enable  output  1  registered write enable.
REQ-015 out_payload  output  PAYLOAD_W  registered payload.
REQ-016 cnt_clr  input  1  synchronous clear of all counters.
REQ-017 stall_cnt  output  CNT_W  cycles with stall[STAGE]=1.
REQ-018 bubble_cnt  output  CNT_W  bubbles inserted.
REQ-019 flush_cnt  output  CNT_W  flush cycles that discarded a valid entry.

Function
REQ-020 SHALL evaluate a per-cycle action with strict priority: RESET (rst) > FLUSH (flush) > BUBBLE (stall[STAGE]=1 and stall[STAGE+1]=0) > CAPTURE (stall[STAGE]=0) > HOLD (otherwise).
REQ-021 SHALL, on FLUSH and BUBBLE, load out_valid=0, out_w_enable=0, out_payload=NOP_PAYLOAD at the next edge.
REQ-022 SHALL, on CAPTURE, load out_valid=in_valid, out_w_enable=in_w_enable&in_valid, out_payload=in_payload; latency is exactly one cycle.
REQ-023 SHALL, on HOLD, keep all three outputs unchanged, for any number of consecutive cycles.
REQ-024 SHALL apply FLUSH even when stall[STAGE+1]=1; the held entry is discarded.
REQ-025 SHALL ignore stall bits other than STAGE and STAGE+1.
REQ-026 SHALL increment stall_cnt on every cycle with stall[STAGE]=1 and no rst/cnt_clr, including FLUSH cycles.
REQ-027 SHALL increment bubble_cnt only on BUBBLE cycles.
REQ-028 SHALL increment flush_cnt only on FLUSH cycles where out_valid=1 before the edge.
REQ-029 SHALL saturate every counter at 2^CNT_W-1; no wrap-around.
REQ-030 SHALL give cnt_clr priority over increments: all counters become 0 at the edge, and the events of that cycle are not counted.
REQ-031 SHALL leave cnt_clr without effect on out_valid, out_w_enable and out_payload.
REQ-032 SHALL drive all outputs directly from flops; no combinational path from inputs to outputs.

Reset
REQ-033 SHALL, when rst=1 at a rising edge, set out_valid=0, out_w_enable=0, out_payload=NOP_PAYLOAD, stall_cnt=0, bubble_cnt=0, flush_cnt=0, regardless of all other inputs.
REQ-034 SHALL discard any held or in-flight entry on reset asserted mid-stall; the first capture after reset requires stall[STAGE]=0.

Verification
REQ-035 Capture: rst deasserted, stall=6'b0, in_valid=1, in_w_enable=1, in_payload=0x15 -> next cycle out_valid=1, out_w_enable=1, out_payload=0x15, all counters 0.
REQ-036 Bubble then hold: stall=6'b001000 for 1 cycle, then 6'b011000 for 3 cycles -> out_valid=0 with payload NOP after cycle 1 and unchanged through cycle 4; stall_cnt=4, bubble_cnt=1.
REQ-037 Flush over hold: valid entry 0xAB held with stall=6'b011000, flush=1 for 1 cycle -> out_valid=0, out_payload=NOP, flush_cnt=1, stall_cnt incremented.
REQ-038 Saturation with CNT_W=2: stall[STAGE]=1 for 6 cycles -> stall_cnt reads 3 after the third cycle and stays 3; cnt_clr=1 with stall held -> stall_cnt=0 next cycle.
REQ-039 Reset mid-operation: valid entry held, counters nonzero, rst=1 with flush=1 and stall=6'b111111 -> all outputs and counters 0 next cycle.
REQ-040 Invalid-write masking: in_valid=0, in_w_enable=1, stall=0 -> out_valid=0, out_w_enable=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with bubble/flush/hold control and saturating
// performance counters for stall, bubble and flush events.
module pipe_stage_reg #(
    parameter int unsigned          PAYLOAD_W   = 74,
    parameter int unsigned          STALL_W     = 6,
    parameter int unsigned          STAGE       = 3,
    parameter int unsigned          CNT_W       = 16,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_w_enable,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic                 out_w_enable,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int unsigned      STAGE_DN = STAGE + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_CAPTURE,
        ACT_BUBBLE,
        ACT_FLUSH
    } action_e;

    action_e action;
    logic    stall_up;
    logic    stall_dn;
    logic    unused_stall;

    assign stall_up     = stall[STAGE];
    assign stall_dn     = stall[STAGE_DN];
    // Other stages' stall bits are deliberately ignored.
    assign unused_stall = ^stall;

    // Per-cycle action; reset is handled in the registers themselves.
    always_comb begin
        action = ACT_HOLD;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (stall_up && !stall_dn) begin
            action = ACT_BUBBLE;
        end else if (!stall_up) begin
            action = ACT_CAPTURE;
        end
    end

    // Stage contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_w_enable <= 1'b0;
            out_payload  <= NOP_PAYLOAD;
        end else begin
            case (action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    out_valid    <= 1'b0;
                    out_w_enable <= 1'b0;
                    out_payload  <= NOP_PAYLOAD;
                end
                ACT_CAPTURE: begin
                    out_valid    <= in_valid;
                    out_w_enable <= in_w_enable & in_valid;
                    out_payload  <= in_payload;
                end
                default: begin
                    out_valid    <= out_valid;
                    out_w_enable <= out_w_enable;
                    out_payload  <= out_payload;
                end
            endcase
        end
    end

    // Saturating event counters; clear wins over that cycle's events.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (stall_up && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((action == ACT_BUBBLE) && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if ((action == ACT_FLUSH) && out_valid && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance plus a narrow-counter
// instance with a non-zero NOP payload, both driven by the same stimulus.
module tb_pipe_stage_reg;

    typedef logic [79:0] val_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic        in_w_enable;
    logic [73:0] in_payload;
    logic        cnt_clr;

    logic        out_valid,  out_w_enable;
    logic [73:0] out_payload;
    logic [15:0] stall_cnt,  bubble_cnt,  flush_cnt;
    logic        out_valid2, out_w_enable2;
    logic [73:0] out_payload2;
    logic [1:0]  stall_cnt2, bubble_cnt2, flush_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_w_enable(in_w_enable), .in_payload(in_payload),
        .out_valid(out_valid), .out_w_enable(out_w_enable), .out_payload(out_payload),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.CNT_W(2), .NOP_PAYLOAD(74'h3FF)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_w_enable(in_w_enable), .in_payload(in_payload),
        .out_valid(out_valid2), .out_w_enable(out_w_enable2), .out_payload(out_payload2),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2),
        .flush_cnt(flush_cnt2)
    );

    task automatic chk(input string tag, input val_t obs, input val_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic we,
                           input logic [73:0] p);
        chk({tag, ".valid"}, val_t'(out_valid), val_t'(v));
        chk({tag, ".w_en"}, val_t'(out_w_enable), val_t'(we));
        chk({tag, ".payload"}, val_t'(out_payload), val_t'(p));
    endtask

    task automatic chk_cnt(input string tag, input int sc, input int bc, input int fc);
        chk({tag, ".stall_cnt"}, val_t'(stall_cnt), val_t'(sc));
        chk({tag, ".bubble_cnt"}, val_t'(bubble_cnt), val_t'(bc));
        chk({tag, ".flush_cnt"}, val_t'(flush_cnt), val_t'(fc));
    endtask

    task automatic drive(input logic [5:0] s, input logic f, input logic v,
                         input logic we, input logic [73:0] p);
        stall = s; flush = f; in_valid = v; in_w_enable = we; in_payload = p;
    endtask

    initial begin
        rst = 1'b1; cnt_clr = 1'b0;
        drive(6'b000000, 1'b0, 1'b1, 1'b1, 74'h7);
        step();
        chk_out("reset", 1'b0, 1'b0, 74'h0);
        chk_cnt("reset", 0, 0, 0);
        chk("reset.nop2", val_t'(out_payload2), val_t'(74'h3FF));

        rst = 1'b0;
        drive(6'b000000, 1'b0, 1'b1, 1'b1, 74'h15);
        step();
        chk_out("capture", 1'b1, 1'b1, 74'h15);
        chk_cnt("capture", 0, 0, 0);

        drive(6'b000000, 1'b0, 1'b0, 1'b1, 74'h15);
        step();
        chk_out("wen_mask", 1'b0, 1'b0, 74'h15);

        drive(6'b000000, 1'b0, 1'b1, 1'b0, 74'h33);
        step();
        chk_out("capture_nowr", 1'b1, 1'b0, 74'h33);

        drive(6'b001000, 1'b0, 1'b1, 1'b1, 74'h77);
        step();
        chk_out("bubble", 1'b0, 1'b0, 74'h0);
        chk_cnt("bubble", 1, 1, 0);
        chk("bubble.nop2", val_t'(out_payload2), val_t'(74'h3FF));

        drive(6'b011000, 1'b0, 1'b1, 1'b1, 74'h77);
        step(); step(); step();
        chk_out("bubble_hold", 1'b0, 1'b0, 74'h0);
        chk_cnt("bubble_hold", 4, 1, 0);
        chk("sat2.stall_cnt", val_t'(stall_cnt2), val_t'(3));

        drive(6'b000000, 1'b0, 1'b1, 1'b1, 74'hAB);
        step();
        chk_out("capture_ab", 1'b1, 1'b1, 74'hAB);

        drive(6'b011000, 1'b0, 1'b1, 1'b0, 74'h55);
        step();
        chk_out("hold_ab", 1'b1, 1'b1, 74'hAB);
        drive(6'b111011, 1'b0, 1'b1, 1'b0, 74'h55);
        step();
        chk_out("hold_other_bits", 1'b1, 1'b1, 74'hAB);
        chk_cnt("hold_other_bits", 6, 1, 0);

        drive(6'b011000, 1'b1, 1'b1, 1'b1, 74'h55);
        step();
        chk_out("flush_over_hold", 1'b0, 1'b0, 74'h0);
        chk_cnt("flush_over_hold", 7, 1, 1);
        step();
        chk_cnt("flush_empty", 8, 1, 1);

        drive(6'b100111, 1'b0, 1'b1, 1'b1, 74'h12);
        step();
        chk_out("capture_other_bits", 1'b1, 1'b1, 74'h12);
        chk_cnt("capture_other_bits", 8, 1, 1);

        drive(6'b000000, 1'b0, 1'b1, 1'b1, 74'h99);
        cnt_clr = 1'b1;
        step();
        chk_out("clr_capture", 1'b1, 1'b1, 74'h99);
        chk_cnt("clr_capture", 0, 0, 0);

        cnt_clr = 1'b0;
        drive(6'b001000, 1'b0, 1'b1, 1'b1, 74'h99);
        step(); step(); step();
        chk("sat2.third", val_t'(stall_cnt2), val_t'(3));
        chk("sat2.bubble_third", val_t'(bubble_cnt2), val_t'(3));
        step(); step(); step();
        chk("sat2.sixth", val_t'(stall_cnt2), val_t'(3));
        chk("sat2.bubble_sixth", val_t'(bubble_cnt2), val_t'(3));
        chk_cnt("six_bubbles", 6, 6, 0);
        chk_out("six_bubbles", 1'b0, 1'b0, 74'h0);

        cnt_clr = 1'b1;
        step();
        chk("sat2.clr", val_t'(stall_cnt2), val_t'(0));
        chk_cnt("clr_stall", 0, 0, 0);
        cnt_clr = 1'b0;

        drive(6'b000000, 1'b0, 1'b1, 1'b1, 74'h3C);
        step();
        drive(6'b000000, 1'b1, 1'b1, 1'b1, 74'h3C);
        step();
        chk_out("flush_nostall", 1'b0, 1'b0, 74'h0);
        drive(6'b000000, 1'b0, 1'b1, 1'b1, 74'h3C);
        step();
        drive(6'b011000, 1'b0, 1'b1, 1'b1, 74'h3C);
        step();
        chk_out("pre_reset_hold", 1'b1, 1'b1, 74'h3C);
        chk_cnt("pre_reset_hold", 1, 0, 1);

        rst = 1'b1;
        drive(6'b111111, 1'b1, 1'b1, 1'b1, 74'h3C);
        cnt_clr = 1'b0;
        step();
        chk_out("reset_mid", 1'b0, 1'b0, 74'h0);
        chk_cnt("reset_mid", 0, 0, 0);

        rst = 1'b0;
        drive(6'b011000, 1'b0, 1'b1, 1'b1, 74'h44);
        step();
        chk_out("post_reset_hold", 1'b0, 1'b0, 74'h0);
        drive(6'b000000, 1'b0, 1'b1, 1'b1, 74'h44);
        step();
        chk_out("post_reset_capture", 1'b1, 1'b1, 74'h44);
        chk_cnt("post_reset_capture", 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
